coin_table: RTL
===============

Name: coin_table

Overview:
- Owns the coin table: 32 entries of {exist, x[7:0], y[6:0]}. Map 1 uses entries 0..9; map 2 uses entries 16..25.
- Answers read requests from the coin-drawing block: address in, {exist,x,y} word out.
- On request, scans the active map's coins against the player box, clears each collected coin, and updates the score.
- Sits between the player-movement logic and the coin drawer.

Parameters:
- COINS_PER_MAP, 10, live entries per map, starting at that map's base address.
- MAP2_BASE, 16, first entry of map 2.
- PLAYER_W, 4, player box width in pixels.
- PLAYER_H, 4, player box height in pixels.
- SCORE_W, 8, score counter width.

Ports:
- clock  in  1  system clock
- resetn  in  1  reset
- map  in  1  0=map 1, 1=map 2; sampled at scan start
- reload_req  in  1  pulse: re-initialise the whole table
- rd_addr  in  5  drawer read address
- rd_q  out  16  {exist, x[7:0], y[6:0]} of rd_addr, registered
- player_x  in  8  player top-left x
- player_y  in  7  player top-left y
- check_req  in  1  pulse: run a collision scan
- check_busy  out  1  high during INIT and SCAN
- check_done  out  1  1-cycle pulse when a scan completes
- coin_hit  out  1  1-cycle pulse per coin cleared
- score  out  SCORE_W  coins collected, saturating
- all_collected  out  1  no exist bit set in the active map's range
- draw_coin_en  out  1  high in IDLE; enables the drawer

Behaviour:
- Interface: reset resetn, synchronous, active-low; clock clock.
- Storage: 32x16 register array. Read port is independent of the scan.
  - rd_q = table[rd_addr] one cycle after rd_addr is presented.
  - Read during a write of the same entry returns the old value.
- Reset values:
  - rd_q=0, score=0, check_done=0, coin_hit=0, all_collected=0, draw_coin_en=0.
  - State=INIT, init index=0.
  - Reset mid-scan abandons the scan; no coin_hit or check_done is issued.
- INIT (check_busy=1): writes one entry per cycle, i=0..31, then goes to IDLE. INIT takes 32 cycles.
  - i in 0..9: {1, 16+12*i, 20}.
  - i in 16..25 (j=i-16): {1, 10+14*j, 60}.
  - All other entries: 16'h0000.
- IDLE:
  - draw_coin_en=1.
  - check_req → latch map, player_x and player_y → SCAN, starting at base (0 or MAP2_BASE).
  - reload_req → INIT.
  - If check_req and reload_req arrive together, reload wins.
- SCAN (check_busy=1): one entry per cycle, COINS_PER_MAP cycles.
  - Hit test, computed with 9-bit unsigned arithmetic (no wrap):
    - exist=1, and
    - cx+1 >= px and cx <= px+PLAYER_W-1, and
    - cy+1 >= py and cy <= py+PLAYER_H-1.
  - On a hit:
    - clear the exist bit; x and y are preserved.
    - pulse coin_hit in the same cycle as the write.
    - score += 1, saturating at 2^SCORE_W-1.
  - After the last entry (base+COINS_PER_MAP-1) → DONE.
  - check_req during SCAN is ignored.
  - reload_req during SCAN aborts the scan → INIT. Score is kept.
- DONE: check_done pulses for 1 cycle.
  - all_collected is updated from the active map's range.
  - Next state is IDLE.
- all_collected is held between scans. It is cleared by INIT.
- Score is cleared only by resetn.
- Total scan latency: check_req in IDLE at cycle T → check_done at T+COINS_PER_MAP+1.

Optional Feature:
- Macro: COIN_RESPAWN_EN.
- Defined: if DONE finds all_collected=1, go to INIT instead of IDLE.
  - all_collected pulses for the DONE cycle only.
  - Score is kept.
  - Coins reappear 32 cycles later.
- Undefined: DONE always goes to IDLE.
  - all_collected stays 1 until reload_req or resetn.

Test Plan:
- Reset, wait 33 cycles → check_busy=0 and draw_coin_en=1. rd_addr=0 → rd_q={1,16,20}. rd_addr=17 → rd_q={1,24,60}. rd_addr=12 → rd_q=0.
- map=0, player (27,19), check_req → exactly one coin_hit (entry 1, x=28). Entry 1 then reads {0,28,20}. score=1. check_done occurs 11 cycles after check_req.
- Repeat the same check → no coin_hit, score stays 1.
- Player (200,100) → no hit. Player (17,22) → no hit, because y 22 > cy+1=21.
- Collect all 10 map-1 coins → score=10, all_collected=1 at check_done. With COIN_RESPAWN_EN, entry 0 reads exist=1 again 32 cycles after DONE.
- check_req, then reload_req 3 cycles later → no check_done. Table is re-initialised and score is unchanged. Also assert resetn low mid-scan → score=0 and INIT restarts.

Source files
------------

// File: rtl/coin_table.sv
// coin_table: owns the 32-entry coin table of {exist, x[7:0], y[6:0]} words.
// Map 1 lives in entries 0..COINS_PER_MAP-1, and map 2 starts at MAP2_BASE.
// The table is rebuilt one entry per cycle (INIT). On request it scans the active map
// against the player box (SCAN), clears each collected coin and bumps a saturating
// score. It then reports completion (DONE).
//
// Optional build macro COIN_RESPAWN_EN: when DONE finds the active map empty, the
// table is rebuilt (INIT) instead of returning to IDLE.
//
// Ports:
//   clock, resetn      system clock, synchronous active-low reset
//   map                0 = map 1, 1 = map 2 (latched at scan start)
//   reload_req         pulse: rebuild the whole table
//   rd_addr, rd_q      drawer read port, registered, independent of the scan
//   player_x/player_y  player box top-left (latched at scan start)
//   check_req          pulse: start a collision scan
//   check_busy         high during INIT and SCAN
//   check_done         one-cycle pulse when a scan completes
//   coin_hit           one-cycle pulse per coin cleared
//   score              coins collected, saturating
//   all_collected      no coin left in the active map's range
//   draw_coin_en       high in IDLE
module coin_table #(
    parameter int unsigned COINS_PER_MAP = 10,
    parameter int unsigned MAP2_BASE     = 16,
    parameter int unsigned PLAYER_W      = 4,
    parameter int unsigned PLAYER_H      = 4,
    parameter int unsigned SCORE_W       = 8
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               map,
    input  logic               reload_req,
    input  logic [4:0]         rd_addr,
    output logic [15:0]        rd_q,
    input  logic [7:0]         player_x,
    input  logic [6:0]         player_y,
    input  logic               check_req,
    output logic               check_busy,
    output logic               check_done,
    output logic               coin_hit,
    output logic [SCORE_W-1:0] score,
    output logic               all_collected,
    output logic               draw_coin_en
);

    typedef enum logic [1:0] {StInit, StIdle, StScan, StDone} state_e;

    state_e             state_q, state_d;
    logic [15:0]        entries [32];
    logic [4:0]         init_idx_q, init_idx_d;
    logic [4:0]         scan_idx_q, scan_idx_d;
    logic               map_q, map_d;
    logic [7:0]         px_q, px_d;
    logic [6:0]         py_q, py_d;
    logic [SCORE_W-1:0] score_q;
    logic               all_q, all_d;

    logic               we;
    logic [4:0]         waddr;
    logic [15:0]        wdata;
    logic               hit;
    logic               hit_now;
    logic               done_now;
    logic               any_exist;
    logic [4:0]         base;
    logic [4:0]         last;
    logic [15:0]        cur;
    logic [8:0]         cx, cy, pxw, pyw;

    // Power-up contents of one entry.
    function automatic logic [15:0] init_word(input logic [4:0] i);
        int unsigned n;
        logic [15:0] w;
        n = 32'(i);
        w = 16'h0000;
        if (n < COINS_PER_MAP) begin
            w = {1'b1, 8'(32'd16 + 32'd12 * n), 7'd20};
        end else if (n >= MAP2_BASE && n < MAP2_BASE + COINS_PER_MAP) begin
            w = {1'b1, 8'(32'd10 + 32'd14 * (n - MAP2_BASE)), 7'd60};
        end
        return w;
    endfunction

    assign base = map_q ? 5'(MAP2_BASE) : 5'd0;
    assign last = base + 5'(COINS_PER_MAP - 1);

    // Hit test in 9 bits so the +1 / +W-1 edges cannot wrap.
    always_comb begin
        cur = entries[scan_idx_q];
        cx  = {1'b0, cur[14:7]};
        cy  = {2'b00, cur[6:0]};
        pxw = {1'b0, px_q};
        pyw = {2'b00, py_q};
        hit = cur[15]
              && (cx + 9'd1 >= pxw) && (cx <= pxw + 9'(PLAYER_W - 1))
              && (cy + 9'd1 >= pyw) && (cy <= pyw + 9'(PLAYER_H - 1));
    end

    always_comb begin
        any_exist = 1'b0;
        for (int unsigned k = 0; k < COINS_PER_MAP; k++) begin
            any_exist = any_exist | entries[base + 5'(k)][15];
        end
    end

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        scan_idx_d = scan_idx_q;
        map_d      = map_q;
        px_d       = px_q;
        py_d       = py_q;
        we         = 1'b0;
        waddr      = init_idx_q;
        wdata      = init_word(init_idx_q);
        hit_now    = 1'b0;
        done_now   = 1'b0;

        unique case (state_q)
            StInit: begin
                if (reload_req) begin
                    init_idx_d = '0;
                end else begin
                    we         = 1'b1;
                    init_idx_d = init_idx_q + 5'd1;
                    if (init_idx_q == 5'd31) state_d = StIdle;
                end
            end
            StIdle: begin
                if (reload_req) begin
                    state_d    = StInit;
                    init_idx_d = '0;
                end else if (check_req) begin
                    state_d    = StScan;
                    map_d      = map;
                    px_d       = player_x;
                    py_d       = player_y;
                    scan_idx_d = map ? 5'(MAP2_BASE) : 5'd0;
                end
            end
            StScan: begin
                if (reload_req) begin
                    // Abort: the current entry is neither cleared nor scored.
                    state_d    = StInit;
                    init_idx_d = '0;
                end else begin
                    if (hit) begin
                        we      = 1'b1;
                        waddr   = scan_idx_q;
                        wdata   = {1'b0, cur[14:0]};
                        hit_now = 1'b1;
                    end
                    if (scan_idx_q == last) begin
                        state_d = StDone;
                    end else begin
                        scan_idx_d = scan_idx_q + 5'd1;
                    end
                end
            end
            StDone: begin
                done_now = 1'b1;
`ifdef COIN_RESPAWN_EN
                state_d = (reload_req || !any_exist) ? StInit : StIdle;
`else
                state_d = reload_req ? StInit : StIdle;
`endif
                if (state_d == StInit) init_idx_d = '0;
            end
        endcase

        // INIT always clears the flag, so with respawn it only shows during DONE.
        all_d = all_q;
        if (state_d == StInit) begin
            all_d = 1'b0;
        end else if (state_q == StDone) begin
            all_d = !any_exist;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= StInit;
            init_idx_q <= '0;
            scan_idx_q <= '0;
            map_q      <= 1'b0;
            px_q       <= '0;
            py_q       <= '0;
            score_q    <= '0;
            all_q      <= 1'b0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            scan_idx_q <= scan_idx_d;
            map_q      <= map_d;
            px_q       <= px_d;
            py_q       <= py_d;
            all_q      <= all_d;
            rd_q       <= entries[rd_addr];
            if (hit_now && score_q != '1) score_q <= score_q + SCORE_W'(1);
        end
    end

    // Table storage is not reset; INIT rebuilds every entry after reset.
    always_ff @(posedge clock) begin
        if (resetn && we) entries[waddr] <= wdata;
    end

    // Gated by resetn so a reset landing mid-scan never emits a hit or done pulse.
    assign coin_hit      = resetn && hit_now;
    assign check_done    = resetn && done_now;
    assign check_busy    = (state_q == StInit) || (state_q == StScan);
    assign draw_coin_en  = (state_q == StIdle);
    assign all_collected = (state_q == StDone) ? !any_exist : all_q;
    assign score         = score_q;

endmodule
